// File: rtl/p_ram_dp.sv
// -----------------------------------------------------------------------------
// p_ram_dp - simple-dual-port RAM with one write port and one registered read
// port on a single clock.
//
// Behaviour summary:
//   * A read request accepted on an edge presents the addressed word on `out`
//     after that edge, and `out_valid` is high for that one cycle.
//   * A read and a write to the same address on the same edge follow the
//     WRITE_FIRST policy. 1 means the new data is forwarded. 0 means the old
//     contents are returned. The write always lands.
//   * With CLEAR_ON_RESET=1, reset starts a sweep that zeroes one word per
//     edge. `busy` is high during the sweep, and all accesses are ignored.
//     With CLEAR_ON_RESET=0, reset leaves the contents untouched.
//
// Parameters:
//   BIT_WIDTH      word width in bits
//   SEL_WIDTH      address width (DEPTH = 2**SEL_WIDTH words)
//   WRITE_FIRST    same-address read-during-write policy (1 new, 0 old)
//   CLEAR_ON_RESET 1: reset triggers the zeroing sweep, 0: contents retained
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          synchronous, active-high
//   in             write data
//   write_address  write word select
//   load           write enable
//   read_address   read word select
//   read           read request
//   out            registered read data
//   out_valid      one-cycle strobe: out carries data of last edge's request
//   busy           clear sweep in progress; accesses are ignored
// -----------------------------------------------------------------------------
module p_ram_dp #(
  parameter int BIT_WIDTH      = 8,
  parameter int SEL_WIDTH      = 4,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic [SEL_WIDTH-1:0] write_address,
  input  logic                 load,
  input  logic [SEL_WIDTH-1:0] read_address,
  input  logic                 read,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int DEPTH = 2 ** SEL_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // State chosen on a reset edge. The sweep only exists when it is enabled.
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  // Storage array. It is never reset, so it maps onto block RAM. Zeroing goes
  // through the same single write port as normal writes.
  logic [BIT_WIDTH-1:0] mem_q [DEPTH];

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [BIT_WIDTH-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  // Write-port mux: the sweep and the user port share it.
  logic                 mem_we;
  logic [SEL_WIDTH-1:0] mem_waddr;
  logic [BIT_WIDTH-1:0] mem_wdata;

  // Same-address collision on this edge. It only matters in READY.
  logic                 rdw_hit;
  logic                 sweep_last;

  assign rdw_hit    = load && read && (write_address == read_address);
  assign sweep_last = (clr_ptr_q == {SEL_WIDTH{1'b1}});

  // Next-state, write-port and read-data logic.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = write_address;
    mem_wdata   = in;

    case (state_q)
      ST_CLEAR: begin
        // One word per edge. User load/read are ignored, and out keeps the
        // zero it got on the reset edge.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + SEL_WIDTH'(1);
        if (sweep_last) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        mem_we = load;
        if (read) begin
          out_valid_d = 1'b1;
          // mem_q still holds pre-edge contents here. That gives read-first
          // behaviour by default; write-first forwards the incoming word.
          if ((WRITE_FIRST != 0) && rdw_hit) begin
            out_d = in;
          end else begin
            out_d = mem_q[read_address];
          end
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase

    // A reset edge performs no access of any kind.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Control and output registers, with a synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clr_ptr_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Memory write. This block has no reset, so the array infers as RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_p_ram_dp.sv
// -----------------------------------------------------------------------------
// Testbench for p_ram_dp. Two instances share one stimulus stream:
//   u_a : WRITE_FIRST=1, CLEAR_ON_RESET=1
//   u_b : WRITE_FIRST=0, CLEAR_ON_RESET=0
// A behavioural model of each memory predicts out, out_valid and busy.
// Words of u_b that were never written are tracked as unknown and not checked.
// -----------------------------------------------------------------------------
module tb_p_ram_dp;

  logic       clock;
  logic       reset;
  logic [7:0] din;
  logic [3:0] wa;
  logic       load;
  logic [3:0] ra;
  logic       rd;
  logic [7:0] out_a, out_b;
  logic       ov_a, ov_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  p_ram_dp #(.BIT_WIDTH(8), .SEL_WIDTH(4), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_a (
    .clock(clock), .reset(reset), .in(din), .write_address(wa), .load(load),
    .read_address(ra), .read(rd), .out(out_a), .out_valid(ov_a), .busy(busy_a)
  );

  p_ram_dp #(.BIT_WIDTH(8), .SEL_WIDTH(4), .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u_b (
    .clock(clock), .reset(reset), .in(din), .write_address(wa), .load(load),
    .read_address(ra), .read(rd), .out(out_b), .out_valid(ov_b), .busy(busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model (index 0 = u_a, 1 = u_b) ----------------
  bit         m_wf  [2] = '{1'b1, 1'b0};
  bit         m_cor [2] = '{1'b1, 1'b0};
  logic [7:0] m_mem   [2][16];
  bit         m_known [2][16];
  int         m_left  [2];     // words still to be cleared (0 = ready)
  int         m_ptr   [2];
  logic [7:0] m_out   [2];
  bit         m_outk  [2];     // m_out is a defined value
  bit         m_outv  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_ptr[k] = 0; m_out[k] = 8'h00; m_outk[k] = 1'b0; m_outv[k] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_mem[k][i] = 8'h00; m_known[k][i] = 1'b0;
      end
    end
  end

  // Apply one rising edge to the model, using the inputs that were driven.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_out[k] = 8'h00; m_outk[k] = 1'b1; m_outv[k] = 1'b0;
        m_ptr[k] = 0;
        m_left[k] = m_cor[k] ? 16 : 0;
      end else if (m_left[k] > 0) begin
        m_mem[k][m_ptr[k]] = 8'h00;
        m_known[k][m_ptr[k]] = 1'b1;
        m_ptr[k] = (m_ptr[k] + 1) % 16;
        m_left[k]--;
        m_outv[k] = 1'b0;
      end else begin
        if (rd) begin
          if (load && wa == ra && m_wf[k]) begin
            m_out[k] = din; m_outk[k] = 1'b1;
          end else begin
            m_out[k] = m_mem[k][ra]; m_outk[k] = m_known[k][ra];
          end
          m_outv[k] = 1'b1;
        end else begin
          m_outv[k] = 1'b0;
        end
        if (load) begin
          m_mem[k][wa] = din; m_known[k][wa] = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle. Inputs change on the falling edge; outputs are sampled there.
  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    load = 1'b0; rd = 1'b0; wa = 4'd0; ra = 4'd0; din = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int e;
    reset = 1'b1; idle_inputs();
    cyc(); cyc();
    n_checks++; if (out_a !== 8'h00 || ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_a got=%h/%b exp=00/0", out_a, ov_a); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy_a got=%b exp=1", busy_a); end
    n_checks++; if (out_b !== 8'h00 || ov_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b got=%h/%b/%b exp=00/0/0", out_b, ov_b, busy_b); end
    // Release reset, and attempt an access to word 7 throughout the sweep.
    reset = 1'b0;
    load = 1'b1; wa = 4'd7; din = 8'hAA; rd = 1'b1; ra = 4'd7;
    e = 0;
    do begin
      cyc(); e++;
      if (busy_a === 1'b1) begin
        n_checks++; if (ov_a !== 1'b0 || out_a !== 8'h00) begin n_fail++; $display("FAIL sweep_blocked_a edge=%0d got=%h/%b exp=00/0", e, out_a, ov_a); end
      end
    end while (busy_a === 1'b1 && e < 40);
    idle_inputs();
    n_checks++; if (e != 16) begin n_fail++; $display("FAIL sweep_len got=%0d exp=16", e); end
  endtask

  task automatic test_clear_contents();
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1; ra = 4'(i);
      cyc();
      n_checks++; if (out_a !== 8'h00 || ov_a !== 1'b1) begin n_fail++; $display("FAIL cleared_word%0d got=%h/%b exp=00/1", i, out_a, ov_a); end
      if (i == 7) begin
        // u_b was already ready, so the access that u_a ignored wrote AA into it.
        n_checks++; if (out_b !== 8'hAA) begin n_fail++; $display("FAIL b_word7 got=%h exp=aa", out_b); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      load = 1'b1; wa = 4'(i); din = 8'(i * 17);
      cyc();
    end
    idle_inputs();
    for (int i = 15; i >= 0; i--) begin
      rd = 1'b1; ra = 4'(i);
      cyc();
      v = 8'(i * 17);
      n_checks++; if (out_a !== v || ov_a !== 1'b1) begin n_fail++; $display("FAIL wr_rd_a addr=%0d got=%h/%b exp=%h/1", i, out_a, ov_a, v); end
      n_checks++; if (out_b !== v || ov_b !== 1'b1) begin n_fail++; $display("FAIL wr_rd_b addr=%0d got=%h/%b exp=%h/1", i, out_b, ov_b, v); end
    end
    rd = 1'b0;
    cyc();
    n_checks++; if (ov_a !== 1'b0 || out_a !== 8'h00) begin n_fail++; $display("FAIL rd_drop_a got=%h/%b exp=00/0", out_a, ov_a); end
    n_checks++; if (ov_b !== 1'b0 || out_b !== 8'h00) begin n_fail++; $display("FAIL rd_drop_b got=%h/%b exp=00/0", out_b, ov_b); end
  endtask

  task automatic test_read_during_write();
    idle_inputs();
    load = 1'b1; wa = 4'd3; din = 8'h11;
    cyc();
    load = 1'b1; wa = 4'd3; din = 8'h5A; rd = 1'b1; ra = 4'd3;
    cyc();
    n_checks++; if (out_a !== 8'h5A || ov_a !== 1'b1) begin n_fail++; $display("FAIL rdw_write_first got=%h/%b exp=5a/1", out_a, ov_a); end
    n_checks++; if (out_b !== 8'h11 || ov_b !== 1'b1) begin n_fail++; $display("FAIL rdw_read_first got=%h/%b exp=11/1", out_b, ov_b); end
    load = 1'b0;
    cyc();
    n_checks++; if (out_a !== 8'h5A) begin n_fail++; $display("FAIL rdw_after_a got=%h exp=5a", out_a); end
    n_checks++; if (out_b !== 8'h5A) begin n_fail++; $display("FAIL rdw_after_b got=%h exp=5a", out_b); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      reset = ($urandom_range(0, 99) == 0);
      load  = $urandom_range(0, 1);
      rd    = $urandom_range(0, 2) != 0;
      wa    = 4'($urandom_range(0, 15));
      ra    = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      din   = 8'($urandom);
      cyc();
      n_checks++; if (ov_a !== m_outv[0] || busy_a !== (m_left[0] != 0)) begin n_fail++; $display("FAIL rand_ctl_a t=%0d got=%b/%b exp=%b/%b", t, ov_a, busy_a, m_outv[0], m_left[0] != 0); end
      n_checks++; if (ov_b !== m_outv[1] || busy_b !== 1'b0) begin n_fail++; $display("FAIL rand_ctl_b t=%0d got=%b/%b exp=%b/0", t, ov_b, busy_b, m_outv[1]); end
      if (m_outk[0]) begin
        n_checks++; if (out_a !== m_out[0]) begin n_fail++; $display("FAIL rand_out_a t=%0d got=%h exp=%h", t, out_a, m_out[0]); end
      end
      if (m_outk[1]) begin
        n_checks++; if (out_b !== m_out[1]) begin n_fail++; $display("FAIL rand_out_b t=%0d got=%h exp=%h", t, out_b, m_out[1]); end
      end
    end
    reset = 1'b0; idle_inputs();
    // Let any sweep started by a random reset finish.
    for (int t = 0; t < 20; t++) cyc();
  endtask

  task automatic test_reset_mid_sweep_and_retention();
    int e;
    idle_inputs();
    // Word 5 = 3C. A read is also issued so that out_valid is high before the reset.
    load = 1'b1; wa = 4'd5; din = 8'h3C; rd = 1'b1; ra = 4'd0;
    cyc();
    // Reset edge with load/read active: neither may take effect.
    reset = 1'b1; load = 1'b1; wa = 4'd5; din = 8'hFF; rd = 1'b1; ra = 4'd5;
    cyc();
    n_checks++; if (out_b !== 8'h00 || ov_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL retain_reset_b got=%h/%b/%b exp=00/0/0", out_b, ov_b, busy_b); end
    reset = 1'b0; idle_inputs();
    for (int i = 0; i < 7; i++) begin
      cyc();
      n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL retain_busy_b got=%b exp=0", busy_b); end
    end
    // Reset arrives at sweep edge 8 and restarts the sweep of u_a.
    reset = 1'b1;
    cyc();
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midsweep_busy got=%b exp=1", busy_a); end
    reset = 1'b0;
    e = 0;
    do begin
      cyc(); e++;
    end while (busy_a === 1'b1 && e < 40);
    n_checks++; if (e != 16) begin n_fail++; $display("FAIL midsweep_len got=%0d exp=16", e); end
    for (int i = 0; i < 16; i++) begin
      rd = 1'b1; ra = 4'(i);
      cyc();
      n_checks++; if (out_a !== 8'h00 || ov_a !== 1'b1) begin n_fail++; $display("FAIL midsweep_word%0d got=%h/%b exp=00/1", i, out_a, ov_a); end
      if (i == 5) begin
        n_checks++; if (out_b !== 8'h3C || ov_b !== 1'b1) begin n_fail++; $display("FAIL retain_word5 got=%h/%b exp=3c/1", out_b, ov_b); end
      end
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_clear_contents();
    test_write_read();
    test_read_during_write();
    test_random();
    test_reset_mid_sweep_and_retention();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
